// File: rtl/riscv_pkg.sv
// Shared RV32I constants, loader FSM encoding and the field bundle
// consumed by the instruction encoder.
package riscv_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into an RV32I word and flags
// unencodable inputs (reserved formats, odd branch/jump offsets).
module instr_encoder
    import riscv_pkg::*;
(
    input  fields_t     fld_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic shift_imm;
    assign shift_imm = (fld_i.op == OP_IMM) &&
                       ((fld_i.f3 == F3_SLLI) || (fld_i.f3 == F3_SRXI));

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (fld_i.fmt)
            FMT_R: word_o = {1'b0, fld_i.f7b5, 5'b0, fld_i.rs2, fld_i.rs1,
                             fld_i.f3, fld_i.rd, fld_i.op};
            FMT_I: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (shift_imm)
                    word_o = {1'b0, fld_i.f7b5, 5'b0, fld_i.imm[4:0], fld_i.rs1,
                              fld_i.f3, fld_i.rd, fld_i.op};
                else
                    word_o = {fld_i.imm[11:0], fld_i.rs1, fld_i.f3, fld_i.rd, fld_i.op};
            end
            FMT_S: word_o = {fld_i.imm[11:5], fld_i.rs2, fld_i.rs1, fld_i.f3,
                             fld_i.imm[4:0], fld_i.op};
            FMT_B: begin
                word_o  = {fld_i.imm[12], fld_i.imm[10:5], fld_i.rs2, fld_i.rs1,
                           fld_i.f3, fld_i.imm[4:1], fld_i.imm[11], fld_i.op};
                legal_o = ~fld_i.imm[0];
            end
            FMT_U: word_o = {fld_i.imm[31:12], fld_i.rd, fld_i.op};
            FMT_J: begin
                word_o  = {fld_i.imm[20], fld_i.imm[10:1], fld_i.imm[11],
                           fld_i.imm[19:12], fld_i.rd, fld_i.op};
                legal_o = ~fld_i.imm[0];
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Streams instruction fields in, encodes them and writes the words to
// consecutive instruction-memory addresses, one session per start.
module instr_loader
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [10:0] word_count,
    output logic        done,
    output logic        err
);

    localparam logic [10:0] MAXW = 11'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        last_q, last_d;

    fields_t     fld;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign fld = '{fmt: in_fmt, op: in_op, f3: in_funct3, f7b5: in_funct7b5,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    instr_encoder u_enc (
        .fld_i   (fld),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_RUN;
                count_d = '0;
                err_d   = 1'b0;
            end
            ST_RUN: if (in_valid) begin
                if (enc_legal) begin
                    wdata_d = enc_word;
                    last_d  = in_last;
                    state_d = ST_WR;
                end else begin
                    err_d = 1'b1;
                    if (in_last) state_d = ST_DONE;
                end
            end
            ST_WR: begin
                count_d = count_q + 11'd1;
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (count_d == MAXW) begin
                    // Capacity exhausted before the stream said it was finished.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode straight from state so reset kills a pending write at once.
    assign in_ready   = (state_q == ST_RUN);
    assign mem_we     = (state_q == ST_WR);
    assign done       = (state_q == ST_DONE);
    assign mem_addr   = BASE_ADDR + {19'd0, count_q, 2'b00};
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench: expected writes queued at issue, checked by per-DUT monitors.
module tb_instr_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_op = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        rdy_a, we_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [10:0] wc_a;
    logic        rdy_b, we_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [10:0] wc_b;

    wr_t q_a[$];
    wr_t q_b[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    instr_loader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .word_count(wc_a),
        .done(done_a), .err(err_a)
    );

    instr_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .word_count(wc_b),
        .done(done_b), .err(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        wr_t e;
        if (we_a) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_write: addr %h data %h, none expected", addr_a, wdata_a);
            end else begin
                e = q_a.pop_front();
                chk("a_addr", addr_a, e.addr);
                chk("a_data", wdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t e;
        if (we_b) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_write: addr %h data %h, none expected", addr_b, wdata_b);
            end else begin
                e = q_b.pop_front();
                chk("b_addr", addr_b, e.addr);
                chk("b_data", wdata_b, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input bit to_b);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Presents one field set and returns #1 after the accepting edge.
    task automatic send(input bit to_b, input logic [2:0] f, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        int n;
        in_fmt = f; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!(to_b ? rdy_b : rdy_a) && n < 20) begin
            tick(); n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL handshake_timeout: in_ready low for %0d cycles, expected high", n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // Reset values on both instances
        tick(); tick();
        chk("rst_ready",  32'(rdy_a), 32'd0);
        chk("rst_we",     32'(we_a), 32'd0);
        chk("rst_addr",   addr_a, 32'h0);
        chk("rst_wdata",  wdata_a, 32'h0);
        chk("rst_wc",     32'(wc_a), 32'd0);
        chk("rst_done",   32'(done_a), 32'd0);
        chk("rst_err",    32'(err_a), 32'd0);
        chk("rst_addr_b", addr_b, 32'hFFFF_FFFC);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(rdy_a), 32'd0);

        // R-type pair
        pulse_start(1'b0);
        chk("run_ready", 32'(rdy_a), 32'd1);
        q_a.push_back('{32'h0, 32'h002081B3});
        send(1'b0, 3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        q_a.push_back('{32'h4, 32'h402081B3});
        send(1'b0, 3'd0, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        tick();
        chk("r_done", 32'(done_a), 32'd1);
        chk("r_wc", 32'(wc_a), 32'd2);
        tick();

        // I, S, shift-immediate, U, B, J in one session
        pulse_start(1'b0);
        chk("start_clr_wc", 32'(wc_a), 32'd0);
        q_a.push_back('{32'h0, 32'h00500093});
        send(1'b0, 3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        q_a.push_back('{32'h4, 32'h0020A423});
        send(1'b0, 3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        tick();
        chk("is_wc", 32'(wc_a), 32'd2);
        q_a.push_back('{32'h8, 32'h40335293});
        send(1'b0, 3'd1, 7'h13, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
        q_a.push_back('{32'hC, 32'h123453B7});
        send(1'b0, 3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        q_a.push_back('{32'h10, 32'hFE208EE3});
        send(1'b0, 3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
        q_a.push_back('{32'h14, 32'h008000EF});
        send(1'b0, 3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        chk("j_we", 32'(we_a), 32'd1);
        chk("j_done_early", 32'(done_a), 32'd0);
        tick();
        chk("j_done", 32'(done_a), 32'd1);
        chk("j_wc", 32'(wc_a), 32'd6);
        tick();
        chk("j_done_pulse", 32'(done_a), 32'd0);

        // Illegal format and odd branch offset
        pulse_start(1'b0);
        send(1'b0, 3'd6, 7'h33, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        chk("ill_err", 32'(err_a), 32'd1);
        chk("ill_ready", 32'(rdy_a), 32'd1);
        chk("ill_wc", 32'(wc_a), 32'd0);
        send(1'b0, 3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
        chk("odd_done", 32'(done_a), 32'd1);
        chk("odd_err", 32'(err_a), 32'd1);
        chk("odd_wc", 32'(wc_a), 32'd0);
        tick();
        pulse_start(1'b0);
        chk("start_clr_err", 32'(err_a), 32'd0);
        q_a.push_back('{32'h0, 32'h123453B7});
        send(1'b0, 3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
        tick(); tick();

        // Capacity limit with address wrap (MAX_WORDS=2, base 0xFFFFFFFC)
        pulse_start(1'b1);
        q_b.push_back('{32'hFFFF_FFFC, 32'h00500093});
        send(1'b1, 3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        q_b.push_back('{32'h0, 32'h00100113});
        send(1'b1, 3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
        tick();
        chk("cap_done", 32'(done_b), 32'd1);
        chk("cap_err", 32'(err_b), 32'd1);
        chk("cap_wc", 32'(wc_b), 32'd2);
        in_fmt = 3'd0; in_op = 7'h33; in_valid = 1'b1;
        begin
            int hi = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (rdy_b) hi++;
            end
            chk("cap_ready_after", 32'(hi), 32'd0);
        end
        in_valid = 1'b0;

        // Reset while a write is pending
        pulse_start(1'b0);
        send(1'b0, 3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        chk("pre_rst_we", 32'(we_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("wr_rst_we", 32'(we_a), 32'd0);
        chk("wr_rst_ready", 32'(rdy_a), 32'd0);
        chk("wr_rst_addr", addr_a, 32'h0);
        chk("wr_rst_wdata", wdata_a, 32'h0);
        chk("wr_rst_wc", 32'(wc_a), 32'd0);
        chk("wr_rst_done", 32'(done_a), 32'd0);
        chk("wr_rst_err", 32'(err_a), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(rdy_a), 32'd0);

        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
